// File: rtl/synth_reg_sequencer.sv
// Script-driven register write sequencer for the synth core.
// Plays (addr, data, delay) entries out as strobed writes, one-shot or looping.
module synth_reg_sequencer #(
  parameter int ADDR_BITS     = 4,
  parameter int DATA_BITS     = 8,
  parameter int DEPTH         = 16,
  parameter int DELAY_BITS    = 8,
  parameter int STROBE_CYCLES = 1,
  parameter int GAP_CYCLES    = 10,
  parameter int TICK_DIV      = 256,
  localparam int IDX_BITS     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_en,
  input  logic [IDX_BITS-1:0]   load_idx,
  input  logic [ADDR_BITS-1:0]  load_addr,
  input  logic [DATA_BITS-1:0]  load_data,
  input  logic [DELAY_BITS-1:0] load_delay,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop_en,
  input  logic [IDX_BITS-1:0]   last_idx,
  output logic [ADDR_BITS-1:0]  wr_addr,
  output logic [DATA_BITS-1:0]  wr_data,
  output logic                  wr_strobe,
  output logic                  busy,
  output logic                  done,
  output logic [IDX_BITS-1:0]   cur_idx
);

  localparam int TB = $clog2(TICK_DIV);
  localparam int WB = DELAY_BITS + TB;
  localparam int PB = $clog2(STROBE_CYCLES + GAP_CYCLES + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_STROBE,
    S_GAP,
    S_WAIT
  } state_e;

  typedef struct packed {
    logic [ADDR_BITS-1:0]  addr;
    logic [DATA_BITS-1:0]  data;
    logic [DELAY_BITS-1:0] dly;
  } ent_t;

  ent_t mem [DEPTH];
  ent_t rd_ent;

  state_e               state_q, state_d;
  logic [IDX_BITS-1:0]  cur_idx_q, cur_idx_d;
  logic [IDX_BITS-1:0]  last_q, last_d;
  logic                 loop_q, loop_d;
  logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_BITS-1:0] wr_data_q, wr_data_d;
  logic                 strobe_q, strobe_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [PB-1:0]        pc_q, pc_d;
  logic [WB-1:0]        wc_q, wc_d;
  logic                 eoe;

  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_idx] <= '{addr: load_addr, data: load_data, dly: load_delay};
    end
  end

  // Registering the fetched entry into wr_* is the synchronous RAM read.
  assign rd_ent = mem[cur_idx_q];

  always_comb begin
    state_d   = state_q;
    cur_idx_d = cur_idx_q;
    last_d    = last_q;
    loop_d    = loop_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    strobe_d  = strobe_q;
    done_d    = 1'b0;
    pc_d      = pc_q;
    wc_d      = wc_q;
    eoe       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          loop_d    = loop_en;
          last_d    = last_idx;
          cur_idx_d = '0;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: begin
        wr_addr_d = rd_ent.addr;
        wr_data_d = rd_ent.data;
        strobe_d  = 1'b1;
        wc_d      = WB'(rd_ent.dly) * WB'(TICK_DIV);
        pc_d      = PB'(STROBE_CYCLES - 1);
        state_d   = S_STROBE;
      end
      S_STROBE: begin
        if (pc_q == '0) begin
          strobe_d = 1'b0;
          if (GAP_CYCLES == 0) begin
            if (wc_q == '0) eoe = 1'b1;
            else state_d = S_WAIT;
          end else begin
            pc_d    = PB'(GAP_CYCLES - 1);
            state_d = S_GAP;
          end
        end else begin
          pc_d = pc_q - PB'(1);
        end
      end
      S_GAP: begin
        if (pc_q == '0) begin
          if (wc_q == '0) eoe = 1'b1;
          else state_d = S_WAIT;
        end else begin
          pc_d = pc_q - PB'(1);
        end
      end
      S_WAIT: begin
        if (wc_q <= WB'(1)) eoe = 1'b1;
        else wc_d = wc_q - WB'(1);
      end
      default: state_d = S_IDLE;
    endcase

    if (eoe) begin
      if (cur_idx_q != last_q) begin
        cur_idx_d = cur_idx_q + IDX_BITS'(1);
        state_d   = S_FETCH;
      end else if (loop_q) begin
        cur_idx_d = '0;
        state_d   = S_FETCH;
      end else begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    end

    // Abort truncates any strobe; wr_addr/wr_data keep their last value.
    if (stop && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      strobe_d  = 1'b0;
      done_d    = 1'b0;
      cur_idx_d = cur_idx_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cur_idx_q <= '0;
      last_q    <= '0;
      loop_q    <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      strobe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pc_q      <= '0;
      wc_q      <= '0;
    end else begin
      state_q   <= state_d;
      cur_idx_q <= cur_idx_d;
      last_q    <= last_d;
      loop_q    <= loop_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      strobe_q  <= strobe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pc_q      <= pc_d;
      wc_q      <= wc_d;
    end
  end

  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign wr_strobe = strobe_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cur_idx   = cur_idx_q;

endmodule

// File: tb/tb_synth_reg_sequencer.sv
// Scoreboard bench for synth_reg_sequencer.
// Expected strobe/done events are queued at start and matched on output.
module tb_synth_reg_sequencer;

  localparam int TICK = 4;
  localparam int BASE = 12;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_en;
  logic [3:0] load_idx;
  logic [3:0] load_addr;
  logic [7:0] load_data;
  logic [7:0] load_delay;
  logic       start;
  logic       stop;
  logic       loop_en;
  logic [3:0] last_idx;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_strobe;
  logic       busy;
  logic       done;
  logic [3:0] cur_idx;

  synth_reg_sequencer #(
    .TICK_DIV(TICK)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (load_en),
    .load_idx  (load_idx),
    .load_addr (load_addr),
    .load_data (load_data),
    .load_delay(load_delay),
    .start     (start),
    .stop      (stop),
    .loop_en   (loop_en),
    .last_idx  (last_idx),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_strobe (wr_strobe),
    .busy      (busy),
    .done      (done),
    .cur_idx   (cur_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int         cyc;
    logic [3:0] a;
    logic [7:0] d;
    logic [3:0] i;
  } exp_t;

  exp_t sq[$];
  int   dq[$];

  logic [3:0] sh_a [16];
  logic [7:0] sh_d [16];
  logic [7:0] sh_w [16];

  int   cyc = 0;
  int   t0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   rise_cyc = 0;
  logic prev_s = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)",
               tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_s <= 1'b0;
    end else begin
      prev_s <= wr_strobe;
      if (wr_strobe && !prev_s) begin
        rise_cyc <= cyc;
        chk("strb_sb", 64'(sq.size() != 0), 1);
        if (sq.size() != 0) begin
          chk("strb_cyc", 64'(cyc), 64'(sq[0].cyc));
          chk("strb_addr", 64'(wr_addr), 64'(sq[0].a));
          chk("strb_data", 64'(wr_data), 64'(sq[0].d));
          chk("strb_idx", 64'(cur_idx), 64'(sq[0].i));
          void'(sq.pop_front());
        end
      end
      if (!wr_strobe && prev_s) begin
        chk("strb_len", 64'(cyc - rise_cyc), 1);
      end
      if (done) begin
        chk("done_sb", 64'(dq.size() != 0), 1);
        chk("done_busy", 64'(busy), 0);
        if (dq.size() != 0) begin
          chk("done_cyc", 64'(cyc), 64'(dq[0]));
          void'(dq.pop_front());
        end
      end
    end
  end

  task automatic load(input int idx, input int a, input int d, input int w);
    sh_a[idx]  = 4'(a);
    sh_d[idx]  = 8'(d);
    sh_w[idx]  = 8'(w);
    load_en    = 1'b1;
    load_idx   = 4'(idx);
    load_addr  = 4'(a);
    load_data  = 8'(d);
    load_delay = 8'(w);
    @(negedge clk);
    load_en    = 1'b0;
  endtask

  // Drives start at the current negedge and queues the expected events.
  task automatic run(input int last, input bit lp, input int nstr,
                     input bit wdone);
    int t;
    int idx;
    start    = 1'b1;
    loop_en  = lp;
    last_idx = 4'(last);
    t0  = cyc;
    t   = t0 + 2;
    idx = 0;
    for (int n = 0; n < nstr; n++) begin
      sq.push_back('{cyc: t, a: sh_a[idx], d: sh_d[idx], i: 4'(idx)});
      t   = t + BASE + int'(sh_w[idx]) * TICK;
      idx = (idx == last) ? 0 : idx + 1;
    end
    if (wdone) dq.push_back(t - 1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    for (int k = 0; k < maxc && busy; k++) @(negedge clk);
    if (busy) chk("idle_timeout", 64'(busy), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b0;
    load_en    = 1'b0;
    load_idx   = '0;
    load_addr  = '0;
    load_data  = '0;
    load_delay = '0;
    start      = 1'b0;
    stop       = 1'b0;
    loop_en    = 1'b0;
    last_idx   = '0;
    repeat (2) @(negedge clk);
    chk("rst_addr", 64'(wr_addr), 0);
    chk("rst_data", 64'(wr_data), 0);
    chk("rst_strobe", 64'(wr_strobe), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_idx", 64'(cur_idx), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single one-shot entry
    load(0, 'h2, 'h55, 0);
    run(0, 1'b0, 1, 1'b1);
    chk("busy_rise", 64'(busy), 1);
    wait_idle(200);

    // four entries; entry 3 rewritten mid-run before its fetch
    for (int i = 0; i < 4; i++) load(i, i, 'h10 + i, 0);
    sh_a[3] = 4'hA;
    sh_d[3] = 8'h99;
    run(3, 1'b0, 4, 1'b1);
    repeat (4) @(negedge clk);
    load(3, 'hA, 'h99, 0);
    wait_idle(200);

    // entry 1 delayed; entry 0 loaded in the same cycle as start
    load(1, 'h1, 'h11, 2);
    sh_a[0]    = 4'h5;
    sh_d[0]    = 8'h77;
    sh_w[0]    = 8'h0;
    load_en    = 1'b1;
    load_idx   = 4'h0;
    load_addr  = 4'h5;
    load_data  = 8'h77;
    load_delay = 8'h0;
    run(3, 1'b0, 4, 1'b1);
    load_en = 1'b0;
    wait_idle(300);

    // loop over 0..1, ignored restart, then stop during a strobe
    run(1, 1'b1, 5, 1'b0);
    repeat (19) @(negedge clk);
    start    = 1'b1;
    last_idx = 4'h3;
    loop_en  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (45) @(negedge clk);
    chk("pre_stop_strobe", 64'(wr_strobe), 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_strobe", 64'(wr_strobe), 0);
    chk("stop_busy", 64'(busy), 0);
    chk("stop_idx", 64'(cur_idx), 0);
    repeat (20) @(negedge clk);

    // start and stop together from idle
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    chk("ss_busy1", 64'(busy), 0);
    repeat (3) @(negedge clk);
    chk("ss_busy3", 64'(busy), 0);

    // async reset in WAIT of entry 1, then replay from entry 0
    run(1, 1'b0, 2, 1'b0);
    repeat (27) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_addr", 64'(wr_addr), 0);
    chk("arst_data", 64'(wr_data), 0);
    chk("arst_strobe", 64'(wr_strobe), 0);
    chk("arst_busy", 64'(busy), 0);
    chk("arst_done", 64'(done), 0);
    chk("arst_idx", 64'(cur_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(1, 1'b0, 2, 1'b1);
    wait_idle(200);

    repeat (20) @(negedge clk);
    chk("sb_strobe_left", 64'(sq.size()), 0);
    chk("sb_done_left", 64'(dq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/synth_reg_sequencer.md
Name: synth_reg_sequencer

Overview:
- Parametrised successor to the fixed step-counter write generator that drives the synth core's register port (`uio_in` = {strobe, 3'b000, addr}, `ui_in` = data).
- Holds a loadable script of (addr, data, delay) entries in internal RAM.
- Plays the script out as strobed register writes with programmable strobe width, inter-write gap and per-entry delay.
- Supports one-shot or looping playback; sits between the board top level and the synth core.

Parameters:
- ADDR_BITS, 4, width of synth register address.
- DATA_BITS, 8, width of register data.
- DEPTH, 16, script entries (power of 2, >= 2); IDX_BITS = log2(DEPTH).
- DELAY_BITS, 8, width of per-entry delay field.
- STROBE_CYCLES, 1, wr_strobe high time in clocks (>= 1).
- GAP_CYCLES, 10, strobe-low clocks after each strobe (>= 0).
- TICK_DIV, 256, clocks per delay unit (>= 1).

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- load_en, in, 1, write script entry this cycle.
- load_idx, in, IDX_BITS, entry index to write.
- load_addr, in, ADDR_BITS, entry register address.
- load_data, in, DATA_BITS, entry register data.
- load_delay, in, DELAY_BITS, entry post-write delay in ticks.
- start, in, 1, begin playback (pulse).
- stop, in, 1, abort playback (pulse).
- loop_en, in, 1, loop mode; sampled at start.
- last_idx, in, IDX_BITS, final entry index; sampled at start.
- wr_addr, out, ADDR_BITS, register address to core.
- wr_data, out, DATA_BITS, register data to core.
- wr_strobe, out, 1, write strobe to core.
- busy, out, 1, high in any state except IDLE.
- done, out, 1, one-cycle pulse at the end of a one-shot run.
- cur_idx, out, IDX_BITS, entry currently playing.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; wr_addr, wr_data, wr_strobe, busy, done, cur_idx = 0.
  - Latched loop flag and last index are cleared.
  - Script RAM is not reset; contents are undefined until loaded.
- All outputs are registered.
- RAM:
  - Synchronous write on load_en, accepted in any state.
  - Synchronous read: data is valid one cycle after the FETCH address is presented.
- States: IDLE, FETCH, STROBE, GAP, WAIT.
- IDLE:
  - start=1 and stop=0 → latch loop_en and last_idx; cur_idx = 0; go to FETCH.
  - start while busy is ignored.
- FETCH (1 cycle):
  - Read RAM[cur_idx].
  - Next cycle: load wr_addr/wr_data, set wr_strobe = 1, load delay; go to STROBE.
- STROBE:
  - wr_strobe stays high for exactly STROBE_CYCLES clocks.
  - Then wr_strobe = 0; go to GAP, or to WAIT if GAP_CYCLES = 0.
  - wr_addr/wr_data hold from the first strobe cycle until the next entry's strobe, and across IDLE.
- GAP: GAP_CYCLES clocks, then WAIT.
- WAIT:
  - Lasts delay × TICK_DIV clocks; delay = 0 means zero cycles and falls straight through.
  - Counter is per-entry, not a free-running prescaler, so timing is exact.
- End of entry:
  - cur_idx ≠ last → cur_idx + 1, FETCH.
  - cur_idx = last and loop flag set → cur_idx = 0, FETCH.
  - Otherwise → done = 1 for one cycle, IDLE.
- Entry period (clocks, strobe rise to next strobe rise) = 1 + STROBE_CYCLES + GAP_CYCLES + delay × TICK_DIV. With defaults and delay 0 this is 12.
- stop, in any non-IDLE state:
  - Next edge: state = IDLE, wr_strobe = 0 (an active strobe is truncated).
  - done is not pulsed; cur_idx holds its last value.
  - start and stop in the same cycle: stop wins, no playback.
- Load during playback:
  - A write to an entry not yet fetched takes effect in this run.
  - Write and FETCH of the same index in the same cycle returns the old data.
  - load_en together with start to index 0: the new data is used, because FETCH occurs one cycle later.
- last_idx = 0: single entry, which repeats if the loop flag is set.
- Counter widths: WAIT counter is DELAY_BITS + log2(TICK_DIV) bits, with no overflow at maximum delay.

Test Plan:
- Load entry 0 = (0x2, 0x55, 0); start with loop_en=0, last_idx=0 → busy rises the next cycle; wr_strobe high 1 cycle at start+2 with wr_addr=0x2, wr_data=0x55; done pulses exactly at start+13; busy falls with it.
- Load entries 0..3 = (addr=i, data=0x10+i, delay 0); one-shot, last_idx=3 → four strobes 12 cycles apart; wr_data sequence 0x10..0x13; cur_idx 0..3; one done pulse.
- Entry 1 delay = 2, TICK_DIV=4 in the bench → strobe 1 to strobe 2 spacing = 1+1+10+8 = 20 cycles.
- loop_en=1, last_idx=1 → strobe pattern 0,1,0,1…; no done pulse. Assert stop during a strobe → wr_strobe low and busy=0 on the next edge; done stays 0.
- start and stop asserted together from IDLE → no strobe, busy stays 0. start while busy → ignored; the running sequence timing is unchanged.
- Assert rst_n low mid-WAIT → all outputs 0 immediately, asynchronously. Release rst_n and start again → playback restarts from entry 0 with the RAM contents retained.
